// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master AXI-lite arbiter in front of a single memory slave.
// Master 0 is the instruction fetch unit (read only). Master 1 is the
// load/store unit (read and write). One whole transaction is granted at a
// time, so the slave never sees two outstanding transactions.
// Optional build macro MEM_ARB_RR_EN: round-robin between masters on a tie.
// Without it, the priority is fixed: WR1 > RD1 > RD0.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    // master 0 read
    input  logic [ADDR_W-1:0]   m0_araddr,
    input  logic                m0_arvalid,
    output logic                m0_arready,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic [1:0]          m0_rresp,
    output logic                m0_rvalid,
    input  logic                m0_rready,
    // master 1 read
    input  logic [ADDR_W-1:0]   m1_araddr,
    input  logic                m1_arvalid,
    output logic                m1_arready,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic [1:0]          m1_rresp,
    output logic                m1_rvalid,
    input  logic                m1_rready,
    // master 1 write
    input  logic [ADDR_W-1:0]   m1_awaddr,
    input  logic                m1_awvalid,
    output logic                m1_awready,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    input  logic                m1_wvalid,
    output logic                m1_wready,
    output logic [1:0]          m1_bresp,
    output logic                m1_bvalid,
    input  logic                m1_bready,
    // slave side
    output logic [ADDR_W-1:0]   s_araddr,
    output logic                s_arvalid,
    input  logic                s_arready,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic [1:0]          s_rresp,
    input  logic                s_rvalid,
    output logic                s_rready,
    output logic [ADDR_W-1:0]   s_awaddr,
    output logic                s_awvalid,
    input  logic                s_awready,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    output logic                s_wvalid,
    input  logic                s_wready,
    input  logic [1:0]          s_bresp,
    input  logic                s_bvalid,
    output logic                s_bready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD0  = 2'd1,
        RD1  = 2'd2,
        WR1  = 2'd3
    } state_t;

    state_t state_r;
    state_t state_nxt_s;
    state_t grant_s;
    state_t m1_state_s;
    logic   ar_done_r;
    logic   aw_done_r;
    logic   w_done_r;
    logic   m0_req_s;
    logic   m1_req_s;
    logic   m1_wr_req_s;
    logic   ar_hs_s;
    logic   aw_hs_s;
    logic   w_hs_s;
    logic   r_hs_s;
    logic   b_hs_s;

`ifdef MEM_ARB_RR_EN
    logic   last_grant_r;
`endif

    assign m0_req_s    = m0_arvalid;
    assign m1_wr_req_s = m1_awvalid | m1_wvalid;
    assign m1_req_s    = m1_arvalid | m1_wr_req_s;

    assign ar_hs_s = s_arvalid & s_arready;
    assign aw_hs_s = s_awvalid & s_awready;
    assign w_hs_s  = s_wvalid & s_wready;
    assign r_hs_s  = s_rvalid & s_rready;
    assign b_hs_s  = s_bvalid & s_bready;

    // Pick which transaction IDLE would hand out next; write beats read within master 1.
    always_comb begin
        m1_state_s = m1_wr_req_s ? WR1 : RD1;
        grant_s    = IDLE;
`ifdef MEM_ARB_RR_EN
        if (m0_req_s && m1_req_s) begin
            // tie: the master that was not served last goes first
            grant_s = last_grant_r ? RD0 : m1_state_s;
        end else if (m1_req_s) begin
            grant_s = m1_state_s;
        end else if (m0_req_s) begin
            grant_s = RD0;
        end else begin
            grant_s = IDLE;
        end
`else
        if (m1_req_s) begin
            grant_s = m1_state_s;
        end else if (m0_req_s) begin
            grant_s = RD0;
        end else begin
            grant_s = IDLE;
        end
`endif
    end

    // Next-state logic: leave a transaction only on its final response handshake.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: state_nxt_s = grant_s;
            RD0: begin
                if (r_hs_s) state_nxt_s = IDLE;
                else        state_nxt_s = RD0;
            end
            RD1: begin
                if (r_hs_s) state_nxt_s = IDLE;
                else        state_nxt_s = RD1;
            end
            WR1: begin
                if (b_hs_s) state_nxt_s = IDLE;
                else        state_nxt_s = WR1;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Channel routing: the granted master is wired straight through, everything else idles.
    always_comb begin
        m0_arready = 1'b0;
        m0_rdata   = {DATA_W{1'b0}};
        m0_rresp   = 2'b00;
        m0_rvalid  = 1'b0;
        m1_arready = 1'b0;
        m1_rdata   = {DATA_W{1'b0}};
        m1_rresp   = 2'b00;
        m1_rvalid  = 1'b0;
        m1_awready = 1'b0;
        m1_wready  = 1'b0;
        m1_bresp   = 2'b00;
        m1_bvalid  = 1'b0;
        s_araddr   = {ADDR_W{1'b0}};
        s_arvalid  = 1'b0;
        s_rready   = 1'b0;
        s_awaddr   = {ADDR_W{1'b0}};
        s_awvalid  = 1'b0;
        s_wdata    = {DATA_W{1'b0}};
        s_wstrb    = {(DATA_W/8){1'b0}};
        s_wvalid   = 1'b0;
        s_bready   = 1'b0;
        case (state_r)
            IDLE: begin
                s_arvalid = 1'b0;
            end
            RD0: begin
                s_araddr   = m0_araddr;
                s_arvalid  = m0_arvalid & ~ar_done_r;
                m0_arready = s_arready & ~ar_done_r;
                s_rready   = m0_rready;
                m0_rdata   = s_rdata;
                m0_rresp   = s_rresp;
                m0_rvalid  = s_rvalid;
            end
            RD1: begin
                s_araddr   = m1_araddr;
                s_arvalid  = m1_arvalid & ~ar_done_r;
                m1_arready = s_arready & ~ar_done_r;
                s_rready   = m1_rready;
                m1_rdata   = s_rdata;
                m1_rresp   = s_rresp;
                m1_rvalid  = s_rvalid;
            end
            WR1: begin
                s_awaddr   = m1_awaddr;
                s_awvalid  = m1_awvalid & ~aw_done_r;
                m1_awready = s_awready & ~aw_done_r;
                s_wdata    = m1_wdata;
                s_wstrb    = m1_wstrb;
                s_wvalid   = m1_wvalid & ~w_done_r;
                m1_wready  = s_wready & ~w_done_r;
                s_bready   = m1_bready;
                m1_bresp   = s_bresp;
                m1_bvalid  = s_bvalid;
            end
            default: begin
                s_arvalid = 1'b0;
            end
        endcase
    end

    // State register and per-channel done flags; the flags are cleared whenever IDLE is reached.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            ar_done_r <= 1'b0;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (state_r == IDLE) begin
                ar_done_r <= 1'b0;
                aw_done_r <= 1'b0;
                w_done_r  <= 1'b0;
            end else begin
                ar_done_r <= ar_done_r | ar_hs_s;
                aw_done_r <= aw_done_r | aw_hs_s;
                w_done_r  <= w_done_r | w_hs_s;
            end
        end
    end

`ifdef MEM_ARB_RR_EN
    // Remember which master was granted last (1 = master 1), updated when a grant is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_r <= 1'b0;
        end else if ((state_r == IDLE) && (grant_s != IDLE)) begin
            last_grant_r <= (grant_s != RD0);
        end else begin
            last_grant_r <= last_grant_r;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed, table-driven bench for mem_arbiter.
// Each table row is one clock cycle: inputs are driven just after the rising
// edge and the outputs are compared at the falling edge of the same cycle.
module tb_mem_arbiter;

    localparam logic [31:0] A0 = 32'h8000_0000;
    localparam logic [31:0] A1 = 32'h8000_0040;
    localparam logic [31:0] AW = 32'h8000_1000;
    localparam logic [31:0] WD = 32'hDEAD_BEEF;
    localparam logic [3:0]  WS = 4'hF;

    logic        clk;
    logic        rst;
    logic [31:0] m0_araddr, m1_araddr, m1_awaddr, m1_wdata;
    logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready;
    logic [31:0] m0_rdata, m1_rdata;
    logic [1:0]  m0_rresp, m1_rresp, m1_bresp;
    logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready;
    logic        m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_bvalid, m1_bready;
    logic [3:0]  m1_wstrb;
    logic [31:0] s_araddr, s_rdata, s_awaddr, s_wdata;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [1:0]  s_rresp, s_bresp;
    logic [3:0]  s_wstrb;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
        .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // vld = {m1_awvalid, m1_wvalid, m1_arvalid, m0_arvalid}
    // rdy = {m1_bready, m1_rready, m0_rready}
    // sin = {s_bvalid, s_rvalid, s_wready, s_awready, s_arready}
    // em  = {m1_bvalid, m1_wready, m1_awready, m1_rvalid, m1_arready, m0_rvalid, m0_arready}
    // es  = {s_bready, s_wvalid, s_awvalid, s_rready, s_arvalid}
    typedef struct {
        logic        rst;
        logic [3:0]  vld;
        logic [2:0]  rdy;
        logic [4:0]  sin;
        logic [31:0] d;
        logic [1:0]  r;
        logic [6:0]  em;
        logic [4:0]  es;
        logic [31:0] ea;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic void add(input logic rs, input logic [3:0] vl, input logic [2:0] rd,
                                input logic [4:0] si, input logic [31:0] d, input logic [1:0] r,
                                input logic [6:0] em, input logic [4:0] es, input logic [31:0] ea);
        vec_t v;
        v.rst = rs; v.vld = vl; v.rdy = rd; v.sin = si;
        v.d = d; v.r = r; v.em = em; v.es = es; v.ea = ea;
        tbl.push_back(v);
    endfunction

    task automatic chk(input int row, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL row %0d %s: got %h, expected %h", row, nm, act, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        m0_araddr = A0; m1_araddr = A1; m1_awaddr = AW; m1_wdata = WD; m1_wstrb = WS;
        {m1_awvalid, m1_wvalid, m1_arvalid, m0_arvalid} = 4'b0000;
        {m1_bready, m1_rready, m0_rready} = 3'b000;
        {s_bvalid, s_rvalid, s_wready, s_awready, s_arready} = 5'b00000;
        s_rdata = 32'h0; s_rresp = 2'b00; s_bresp = 2'b00;

        // reset beats every request; then quiet idle
        add(1'b1, 4'b1111, 3'b111, 5'b11111, 32'h0, 2'd0, 7'h00, 5'h00, 32'h0);
        add(1'b0, 4'b0000, 3'b000, 5'b00000, 32'h0, 2'd0, 7'h00, 5'h00, 32'h0);
        // single m0 read, data three cycles after the AR handshake
        add(1'b0, 4'b0001, 3'b001, 5'b00000, 32'h0, 2'd0, 7'b0000000, 5'b00000, 32'h0);
        add(1'b0, 4'b0001, 3'b001, 5'b00001, 32'h0, 2'd0, 7'b0000001, 5'b00011, A0);
        add(1'b0, 4'b0000, 3'b001, 5'b00000, 32'h0, 2'd0, 7'b0000000, 5'b00010, 32'h0);
        add(1'b0, 4'b0000, 3'b001, 5'b00000, 32'h0, 2'd0, 7'b0000000, 5'b00010, 32'h0);
        add(1'b0, 4'b0000, 3'b001, 5'b01000, 32'h0000_0413, 2'd0, 7'b0000010, 5'b00010, 32'h0);
        add(1'b0, 4'b0000, 3'b000, 5'b00000, 32'h0, 2'd0, 7'b0000000, 5'b00000, 32'h0);
        // m0 read with SLVERR response
        add(1'b0, 4'b0001, 3'b001, 5'b00000, 32'h0, 2'd0, 7'b0000000, 5'b00000, 32'h0);
        add(1'b0, 4'b0001, 3'b001, 5'b00001, 32'h0, 2'd0, 7'b0000001, 5'b00011, A0);
        add(1'b0, 4'b0000, 3'b001, 5'b01000, 32'h1234_5678, 2'd2, 7'b0000010, 5'b00010, 32'h0);
        add(1'b0, 4'b0000, 3'b000, 5'b00000, 32'h0, 2'd0, 7'b0000000, 5'b00000, 32'h0);
        // m1 write, W before AW, then B
        add(1'b0, 4'b0100, 3'b100, 5'b00000, 32'h0, 2'd0, 7'b0000000, 5'b00000, 32'h0);
        add(1'b0, 4'b0100, 3'b100, 5'b00100, 32'h0, 2'd0, 7'b0100000, 5'b11000, 32'h0);
        add(1'b0, 4'b1000, 3'b100, 5'b00010, 32'h0, 2'd0, 7'b0010000, 5'b10100, 32'h0);
        add(1'b0, 4'b0000, 3'b100, 5'b10000, 32'h0, 2'd0, 7'b1000000, 5'b10000, 32'h0);
        // back in IDLE one cycle after B: m0 request seen, slave AR the cycle after
        add(1'b0, 4'b0001, 3'b001, 5'b00000, 32'h0, 2'd0, 7'b0000000, 5'b00000, 32'h0);
        add(1'b0, 4'b0001, 3'b001, 5'b00001, 32'h0, 2'd0, 7'b0000001, 5'b00011, A0);
        add(1'b0, 4'b0000, 3'b001, 5'b01000, 32'hCAFE_0001, 2'd0, 7'b0000010, 5'b00010, 32'h0);
        add(1'b0, 4'b0000, 3'b000, 5'b00000, 32'h0, 2'd0, 7'b0000000, 5'b00000, 32'h0);
        // simultaneous reads (last grant was m0): m1 first, then m0
        add(1'b0, 4'b0011, 3'b011, 5'b00000, 32'h0, 2'd0, 7'b0000000, 5'b00000, 32'h0);
        add(1'b0, 4'b0011, 3'b011, 5'b00001, 32'h0, 2'd0, 7'b0000100, 5'b00011, A1);
        add(1'b0, 4'b0001, 3'b011, 5'b01000, 32'h1111_2222, 2'd0, 7'b0001000, 5'b00010, 32'h0);
        add(1'b0, 4'b0001, 3'b001, 5'b00000, 32'h0, 2'd0, 7'b0000000, 5'b00000, 32'h0);
        add(1'b0, 4'b0001, 3'b001, 5'b00001, 32'h0, 2'd0, 7'b0000001, 5'b00011, A0);
        add(1'b0, 4'b0000, 3'b001, 5'b01000, 32'h3333_4444, 2'd0, 7'b0000010, 5'b00010, 32'h0);
        add(1'b0, 4'b0000, 3'b000, 5'b00000, 32'h0, 2'd0, 7'b0000000, 5'b00000, 32'h0);

        // slave stalls: AR held 10 cycles, master rready low 5 cycles, m0 pending throughout
        add(1'b0, 4'b0011, 3'b000, 5'b00000, 32'h0, 2'd0, 7'b0000000, 5'b00000, 32'h0);
        for (int i = 0; i < 10; i++)
            add(1'b0, 4'b0011, 3'b000, 5'b00000, 32'h0, 2'd0, 7'b0000000, 5'b00001, A1);
        add(1'b0, 4'b0011, 3'b000, 5'b00001, 32'h0, 2'd0, 7'b0000100, 5'b00001, A1);
        add(1'b0, 4'b0001, 3'b000, 5'b00000, 32'h0, 2'd0, 7'b0000000, 5'b00000, 32'h0);
        for (int i = 0; i < 5; i++)
            add(1'b0, 4'b0001, 3'b000, 5'b01000, 32'h5A5A_A5A5, 2'd0, 7'b0001000, 5'b00000, 32'h0);
        add(1'b0, 4'b0001, 3'b010, 5'b01000, 32'h5A5A_A5A5, 2'd0, 7'b0001000, 5'b00010, 32'h0);
        add(1'b0, 4'b0001, 3'b001, 5'b00000, 32'h0, 2'd0, 7'b0000000, 5'b00000, 32'h0);
        add(1'b0, 4'b0001, 3'b001, 5'b00001, 32'h0, 2'd0, 7'b0000001, 5'b00011, A0);
        add(1'b0, 4'b0000, 3'b001, 5'b01000, 32'h7777_8888, 2'd0, 7'b0000010, 5'b00010, 32'h0);
        add(1'b0, 4'b0000, 3'b000, 5'b00000, 32'h0, 2'd0, 7'b0000000, 5'b00000, 32'h0);

        // m1 read alone, then a tie with m1 granted last
        add(1'b0, 4'b0010, 3'b010, 5'b00000, 32'h0, 2'd0, 7'b0000000, 5'b00000, 32'h0);
        add(1'b0, 4'b0010, 3'b010, 5'b00001, 32'h0, 2'd0, 7'b0000100, 5'b00011, A1);
        add(1'b0, 4'b0000, 3'b010, 5'b01000, 32'h9999_0000, 2'd0, 7'b0001000, 5'b00010, 32'h0);
        add(1'b0, 4'b0011, 3'b011, 5'b00000, 32'h0, 2'd0, 7'b0000000, 5'b00000, 32'h0);
`ifdef MEM_ARB_RR_EN
        add(1'b0, 4'b0011, 3'b011, 5'b00001, 32'h0, 2'd0, 7'b0000001, 5'b00011, A0);
        add(1'b0, 4'b0010, 3'b011, 5'b01000, 32'hABCD_0000, 2'd0, 7'b0000010, 5'b00010, 32'h0);
        add(1'b0, 4'b0010, 3'b011, 5'b00000, 32'h0, 2'd0, 7'b0000000, 5'b00000, 32'h0);
        add(1'b0, 4'b0010, 3'b011, 5'b00001, 32'h0, 2'd0, 7'b0000100, 5'b00011, A1);
        add(1'b0, 4'b0000, 3'b011, 5'b01000, 32'hABCD_0001, 2'd0, 7'b0001000, 5'b00010, 32'h0);
`else
        add(1'b0, 4'b0011, 3'b011, 5'b00001, 32'h0, 2'd0, 7'b0000100, 5'b00011, A1);
        add(1'b0, 4'b0001, 3'b011, 5'b01000, 32'hABCD_0000, 2'd0, 7'b0001000, 5'b00010, 32'h0);
        add(1'b0, 4'b0001, 3'b011, 5'b00000, 32'h0, 2'd0, 7'b0000000, 5'b00000, 32'h0);
        add(1'b0, 4'b0001, 3'b011, 5'b00001, 32'h0, 2'd0, 7'b0000001, 5'b00011, A0);
        add(1'b0, 4'b0000, 3'b011, 5'b01000, 32'hABCD_0001, 2'd0, 7'b0000010, 5'b00010, 32'h0);
`endif
        add(1'b0, 4'b0000, 3'b000, 5'b00000, 32'h0, 2'd0, 7'b0000000, 5'b00000, 32'h0);

        // reset mid-WR1 after the AW handshake, then a clean m0 read
        add(1'b0, 4'b1100, 3'b100, 5'b00000, 32'h0, 2'd0, 7'b0000000, 5'b00000, 32'h0);
        add(1'b0, 4'b1100, 3'b100, 5'b00010, 32'h0, 2'd0, 7'b0010000, 5'b11100, 32'h0);
        add(1'b1, 4'b0100, 3'b100, 5'b00000, 32'h0, 2'd0, 7'b0000000, 5'b11000, 32'h0);
        add(1'b0, 4'b0001, 3'b001, 5'b00000, 32'h0, 2'd0, 7'b0000000, 5'b00000, 32'h0);
        add(1'b0, 4'b0001, 3'b001, 5'b00001, 32'h0, 2'd0, 7'b0000001, 5'b00011, A0);
        add(1'b0, 4'b0000, 3'b001, 5'b01000, 32'h0BAD_F00D, 2'd0, 7'b0000010, 5'b00010, 32'h0);
        add(1'b0, 4'b0000, 3'b000, 5'b00000, 32'h0, 2'd0, 7'b0000000, 5'b00000, 32'h0);

        @(posedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1;
            rst = tbl[i].rst;
            {m1_awvalid, m1_wvalid, m1_arvalid, m0_arvalid} = tbl[i].vld;
            {m1_bready, m1_rready, m0_rready} = tbl[i].rdy;
            {s_bvalid, s_rvalid, s_wready, s_awready, s_arready} = tbl[i].sin;
            s_rdata = tbl[i].d;
            s_rresp = tbl[i].r;
            s_bresp = tbl[i].r;
            @(negedge clk);
            n_vec++;
            chk(i, "master_flags",
                {25'h0, m1_bvalid, m1_wready, m1_awready, m1_rvalid, m1_arready, m0_rvalid, m0_arready},
                {25'h0, tbl[i].em});
            chk(i, "slave_flags", {27'h0, s_bready, s_wvalid, s_awvalid, s_rready, s_arvalid},
                {27'h0, tbl[i].es});
            if (tbl[i].es[0]) chk(i, "s_araddr", s_araddr, tbl[i].ea);
            if (tbl[i].es[2]) chk(i, "s_awaddr", s_awaddr, AW);
            if (tbl[i].es[3]) begin
                chk(i, "s_wdata", s_wdata, WD);
                chk(i, "s_wstrb", {28'h0, s_wstrb}, {28'h0, WS});
            end
            if (tbl[i].em[1]) begin
                chk(i, "m0_rdata", m0_rdata, tbl[i].d);
                chk(i, "m0_rresp", {30'h0, m0_rresp}, {30'h0, tbl[i].r});
            end
            if (tbl[i].em[3]) begin
                chk(i, "m1_rdata", m1_rdata, tbl[i].d);
                chk(i, "m1_rresp", {30'h0, m1_rresp}, {30'h0, tbl[i].r});
            end
            if (tbl[i].em[6]) chk(i, "m1_bresp", {30'h0, m1_bresp}, {30'h0, tbl[i].r});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
